lcd_hd44780_driver: RTL and testbench

- Physical-layer driver for the 16x2 HD44780 character LCD on the 25 MHz board clock.
- Sits directly downstream of the scoreboard writer, which issues byte-level requests (character codes or DDRAM address commands).
- Runs the power-on init sequence, then serialises each request into a correctly timed RS/DATA/EN cycle and enforces post-command execution waits.

---
 rtl/lcd_hd44780_driver.sv | 201 ++++++++++++++++++++
 tb/tb_lcd_hd44780_driver.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_driver.sv
// HD44780 16x2 write-only driver: power-on init, then one timed RS/DATA/EN cycle per request.
// Optional: define LCD_REQ_FIFO_EN for a 4-entry {rs,data} request FIFO ahead of the engine.
module lcd_hd44780_driver #(
    parameter int POWERUP_CYC    = 375000,
    parameter int SETUP_CYC      = 2,
    parameter int EN_HIGH_CYC    = 12,
    parameter int SHORT_WAIT_CYC = 1000,
    parameter int LONG_WAIT_CYC  = 41000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_data,
    input  logic       req_rs,
    output logic       init_done,
    output logic       busy,
    output logic [7:0] LCD_data,
    output logic       LCD_rs,
    output logic       LCD_rw,
    output logic       LCD_en
);
    localparam int MAX_A = (POWERUP_CYC > LONG_WAIT_CYC) ? POWERUP_CYC : LONG_WAIT_CYC;
    localparam int MAX_B = (SHORT_WAIT_CYC > EN_HIGH_CYC) ? SHORT_WAIT_CYC : EN_HIGH_CYC;
    localparam int MAX_C = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
    localparam int MAXC  = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int CW    = $clog2(MAXC + 1);

    localparam logic [CW-1:0] POWERUP_LAST = CW'(POWERUP_CYC - 1);
    localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LAST      = CW'(EN_HIGH_CYC - 1);
    localparam logic [CW-1:0] SHORT_LAST   = CW'(SHORT_WAIT_CYC - 1);
    localparam logic [CW-1:0] LONG_LAST    = CW'(LONG_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      step_q;
    logic [7:0]      byte_q;
    logic            rs_q;
    logic            init_done_q;
    logic [7:0]      lcd_data_q;
    logic            lcd_rs_q;
    logic            lcd_en_q;

    logic            take;
    logic [7:0]      take_data;
    logic            take_rs;
    logic            is_long;
    logic [CW-1:0]   wait_last;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Clear and home need the long execution time; everything else is short.
    assign is_long   = !rs_q && ((byte_q == 8'h01) || (byte_q == 8'h02));
    assign wait_last = is_long ? LONG_LAST : SHORT_LAST;

`ifdef LCD_REQ_FIFO_EN
    logic [3:0][8:0] fifo_q;
    logic [1:0]      wr_ptr_q;
    logic [1:0]      rd_ptr_q;
    logic [2:0]      count_q;
    logic            push;

    assign req_ready = (count_q != 3'd4);
    assign push      = req_valid && req_ready;
    // Pop decision uses registered count, so a byte pushed into an empty FIFO leaves one cycle later.
    assign take      = (state_q == ST_IDLE) && init_done_q && (count_q != 3'd0);
    assign {take_rs, take_data} = fifo_q[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= {req_rs, req_data};
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (take) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_q + {2'b00, push} - {2'b00, take};
        end
    end
`else
    assign req_ready = (state_q == ST_IDLE);
    assign take      = req_valid && req_ready;
    assign take_data = req_data;
    assign take_rs   = req_rs;
`endif

    // Bus outputs are registered one cycle behind the state, so EN rises SETUP_CYC+1 after entering SETUP.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_POWERUP;
            cnt_q       <= '0;
            step_q      <= '0;
            byte_q      <= '0;
            rs_q        <= 1'b0;
            init_done_q <= 1'b0;
            lcd_data_q  <= '0;
            lcd_rs_q    <= 1'b0;
            lcd_en_q    <= 1'b0;
        end else begin
            lcd_en_q <= (state_q == ST_PULSE);
            if (state_q == ST_SETUP) begin
                lcd_data_q <= byte_q;
                lcd_rs_q   <= rs_q;
            end
            case (state_q)
                ST_POWERUP: begin
                    if (cnt_q == POWERUP_LAST) begin
                        cnt_q   <= '0;
                        step_q  <= '0;
                        byte_q  <= init_byte(2'd0);
                        rs_q    <= 1'b0;
                        state_q <= ST_SETUP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_PULSE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == EN_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q == wait_last) begin
                        cnt_q <= '0;
                        if (!init_done_q && (step_q < 3'd3)) begin
                            step_q  <= step_q + 3'd1;
                            byte_q  <= init_byte(step_q[1:0] + 2'd1);
                            rs_q    <= 1'b0;
                            state_q <= ST_SETUP;
                        end else if (!init_done_q) begin
                            step_q      <= 3'd4;
                            init_done_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (take) begin
                        byte_q  <= take_data;
                        rs_q    <= take_rs;
                        cnt_q   <= '0;
                        state_q <= ST_SETUP;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= ST_POWERUP;
                end
            endcase
        end
    end

    assign init_done = init_done_q;
    assign busy      = (state_q != ST_IDLE);
    assign LCD_data  = lcd_data_q;
    assign LCD_rs    = lcd_rs_q;
    assign LCD_rw    = 1'b0;
    assign LCD_en    = lcd_en_q;

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Randomised self-checking bench: EN pulses and accept times against a timing model of the LCD cycle.
module tb_lcd_hd44780_driver;
    localparam int P  = 20;
    localparam int S  = 2;
    localparam int EH = 3;
    localparam int SW = 10;
    localparam int LW = 30;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, init_done, busy, LCD_rs, LCD_rw, LCD_en;
    logic [7:0] LCD_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int r0 = 0;

    typedef struct { int t; logic [7:0] d; logic rs; int w; bit stable; } pulse_t;
    pulse_t     seen[$];
    pulse_t     cur;
    logic       en_prev = 1'b0;
    logic [8:0] items[$];

    lcd_hd44780_driver #(
        .POWERUP_CYC(P), .SETUP_CYC(S), .EN_HIGH_CYC(EH),
        .SHORT_WAIT_CYC(SW), .LONG_WAIT_CYC(LW)
    ) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_rs(req_rs), .init_done(init_done), .busy(busy),
        .LCD_data(LCD_data), .LCD_rs(LCD_rs), .LCD_rw(LCD_rw), .LCD_en(LCD_en)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Records every EN pulse: rise time, byte/rs at rise, width, and whether the bus held still.
    always @(negedge clock) begin
        if (LCD_en === 1'b1) begin
            if (en_prev !== 1'b1) begin
                cur.t = cyc; cur.d = LCD_data; cur.rs = LCD_rs; cur.w = 1; cur.stable = 1'b1;
            end else begin
                cur.w = cur.w + 1;
                if (LCD_data !== cur.d || LCD_rs !== cur.rs) cur.stable = 1'b0;
            end
        end else if (en_prev === 1'b1) begin
            seen.push_back(cur);
        end
        en_prev = LCD_en;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(negedge clock);
        #1;
    endtask

    // Execution time of one byte on the LCD.
    function automatic int wait_of(input logic [8:0] it);
        return (!it[8] && (it[7:0] == 8'h01 || it[7:0] == 8'h02)) ? LW : SW;
    endfunction

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0;
        repeat (3) tick;
        n_cmp++; if (LCD_en !== 1'b0) begin n_bad++; $display("FAIL reset_en got %b want 0", LCD_en); end
        n_cmp++; if (LCD_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", LCD_data); end
        n_cmp++; if (LCD_rs !== 1'b0) begin n_bad++; $display("FAIL reset_rs got %b want 0", LCD_rs); end
        n_cmp++; if (LCD_rw !== 1'b0) begin n_bad++; $display("FAIL reset_rw got %b want 0", LCD_rw); end
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", req_ready); end
        n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL reset_init_done got %b want 0", init_done); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy got %b want 1", busy); end
        r0 = cyc;
        reset = 1'b0;
    endtask

    // Init sequence, with a character held valid throughout that may only go out after init_done.
    task automatic test_init;
        logic [8:0] ib [4];
        int e_rise [5];
        int t_done, g;
        bit early;
        ib[0] = 9'h038; ib[1] = 9'h00C; ib[2] = 9'h001; ib[3] = 9'h006;
        e_rise[0] = r0 + P + S + 1;
        for (int i = 1; i < 4; i++) e_rise[i] = e_rise[i-1] + S + EH + 1 + wait_of(ib[i-1]);
        seen.delete();
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h41;
        t_done = -1; early = 1'b0;
        for (int i = 0; i < 3000 && t_done < 0; i++) begin
            tick;
            if (init_done === 1'b1) t_done = cyc;
            else if (req_ready === 1'b1) early = 1'b1;
        end
        n_cmp++;
        if (t_done < 0) begin n_bad++; $display("FAIL init_timeout got no init_done want init_done"); req_valid = 1'b0; return; end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL init_ready got %b want 1", req_ready); end
        n_cmp++; if (early) begin n_bad++; $display("FAIL init_early_ready got 1 want 0"); end
        n_cmp++; if (t_done != e_rise[3] + EH + SW) begin n_bad++; $display("FAIL init_done_time got %0d want %0d", t_done, e_rise[3] + EH + SW); end
        tick;
        req_valid = 1'b0;
        e_rise[4] = t_done + 1 + S + 1;
        g = 0;
        while (!(seen.size() >= 5 && busy === 1'b0) && g < 1000) begin tick; g++; end
        n_cmp++;
        if (seen.size() != 5) begin n_bad++; $display("FAIL init_pulse_count got %0d want 5", seen.size()); return; end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (seen[i].t != e_rise[i]) begin n_bad++; $display("FAIL init_rise[%0d] got %0d want %0d", i, seen[i].t, e_rise[i]); end
            n_cmp++; if (seen[i].d !== (i < 4 ? ib[i][7:0] : 8'h41)) begin n_bad++; $display("FAIL init_data[%0d] got %h", i, seen[i].d); end
            n_cmp++; if (seen[i].rs !== (i == 4)) begin n_bad++; $display("FAIL init_rs[%0d] got %b want %b", i, seen[i].rs, i == 4); end
            n_cmp++; if (seen[i].w != EH || !seen[i].stable) begin n_bad++; $display("FAIL init_width[%0d] got %0d/%b want %0d/1", i, seen[i].w, seen[i].stable, EH); end
        end
    endtask

    task automatic test_single;
        int nb, a_t;
        seen.delete();
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h35;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready got %b want 1", req_ready); end
        tick;
        req_valid = 1'b0;
        a_t = cyc; nb = 0;
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            if (nb == 2) begin
                n_cmp++;
                if (LCD_data !== 8'h35 || LCD_rs !== 1'b1) begin n_bad++; $display("FAIL single_bus got %h/%b want 35/1", LCD_data, LCD_rs); end
            end
            tick;
        end
        n_cmp++; if (nb != S + EH + 1 + SW) begin n_bad++; $display("FAIL single_busy_len got %0d want %0d", nb, S + EH + 1 + SW); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready_after got %b want 1", req_ready); end
        n_cmp++;
        if (seen.size() != 1) begin n_bad++; $display("FAIL single_pulses got %0d want 1", seen.size()); return; end
        n_cmp++; if (seen[0].t != a_t + S + 1) begin n_bad++; $display("FAIL single_rise got %0d want %0d", seen[0].t, a_t + S + 1); end
        n_cmp++; if (seen[0].w != EH) begin n_bad++; $display("FAIL single_width got %0d want %0d", seen[0].w, EH); end
    endtask

    // Streams items[] with random idle gaps; DUT is ready again S+EH+1+wait cycles after each accept.
    task automatic run_stream(input string name, input int gap_max);
        int pres[$];
        int acc[$];
        int e_acc, e_prev, k, g, n;
        n = items.size(); k = 0; g = 0;
        seen.delete();
        while (k < n && g < 3000) begin
            if (req_valid !== 1'b1) begin
                pres.push_back(cyc); req_valid = 1'b1; {req_rs, req_data} = items[k];
            end
            if (req_ready === 1'b1) begin
                acc.push_back(cyc + 1); k++;
                tick;
                req_valid = 1'b0;
                repeat ($urandom_range(gap_max, 0)) tick;
            end else begin
                tick;
            end
            g++;
        end
        req_valid = 1'b0;
        g = 0;
        while (!(seen.size() >= n && busy === 1'b0) && g < 3000) begin tick; g++; end
        n_cmp++;
        if (acc.size() != n || seen.size() != n) begin
            n_bad++; $display("FAIL %s_count got %0d acc/%0d pulses want %0d", name, acc.size(), seen.size(), n); return;
        end
        e_prev = 0;
        for (int i = 0; i < n; i++) begin
            e_acc = pres[i] + 1;
            if (i > 0 && e_prev + S + EH + wait_of(items[i-1]) + 2 > e_acc) e_acc = e_prev + S + EH + wait_of(items[i-1]) + 2;
            e_prev = e_acc;
            n_cmp++; if (acc[i] != e_acc) begin n_bad++; $display("FAIL %s_accept[%0d] got %0d want %0d", name, i, acc[i], e_acc); end
            n_cmp++; if (seen[i].t != e_acc + S + 1) begin n_bad++; $display("FAIL %s_rise[%0d] got %0d want %0d", name, i, seen[i].t, e_acc + S + 1); end
            n_cmp++; if ({seen[i].rs, seen[i].d} !== items[i]) begin n_bad++; $display("FAIL %s_byte[%0d] got %h want %h", name, i, {seen[i].rs, seen[i].d}, items[i]); end
            n_cmp++; if (seen[i].w != EH || !seen[i].stable) begin n_bad++; $display("FAIL %s_width[%0d] got %0d/%b want %0d/1", name, i, seen[i].w, seen[i].stable, EH); end
        end
        n_cmp++; if ({LCD_rs, LCD_data} !== items[n-1]) begin n_bad++; $display("FAIL %s_hold_last got %h want %h", name, {LCD_rs, LCD_data}, items[n-1]); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL %s_ready_end got %b want 1", name, req_ready); end
    endtask

    task automatic test_waits;
        items.delete();
        items.push_back(9'h001); items.push_back(9'h101); items.push_back(9'h002); items.push_back(9'h135);
        run_stream("waits", 2);
    endtask

    task automatic test_back_to_back;
        items.delete();
        items.push_back(9'h08A); items.push_back(9'h135); items.push_back(9'h0CA);
        run_stream("b2b", 0);
    endtask

    task automatic test_random;
        logic [7:0] b;
        items.delete();
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            if ($urandom_range(3, 0) == 0) items.push_back({1'b0, ($urandom_range(1, 0) != 0) ? 8'h01 : 8'h02});
            else items.push_back({1'($urandom_range(1, 0)), b});
        end
        run_stream("random", 3);
    endtask

    task automatic test_reset_mid_pulse;
        int g = 0;
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h52;
        while (LCD_en !== 1'b1 && g < 100) begin tick; g++; end
        n_cmp++; if (LCD_en !== 1'b1) begin n_bad++; $display("FAIL midrst_pulse got %b want 1", LCD_en); end
        reset = 1'b1; req_valid = 1'b0;
        tick;
        n_cmp++; if (LCD_en !== 1'b0) begin n_bad++; $display("FAIL midrst_en got %b want 0", LCD_en); end
        n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL midrst_init_done got %b want 0", init_done); end
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready got %b want 0", req_ready); end
        n_cmp++; if (LCD_data !== 8'h00) begin n_bad++; $display("FAIL midrst_data got %h want 00", LCD_data); end
        test_reset;
        test_init;
    endtask

    initial begin
        test_reset;
        test_init;
        test_single;
        test_waits;
        test_back_to_back;
        test_random;
        test_reset_mid_pulse;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
